tbu_window: RTL and testbench



---
 rtl/tbu_window.sv | 164 ++++++++++++++++
 tb/tb_tbu_window.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tbu_window.sv
// rtl/tbu_window.sv - sliding-window Viterbi traceback unit with a 3-segment survivor buffer
//
// Purpose: stores ACS decision vectors in a circular buffer of 3L entries. Each time a
// segment of L vectors completes (with at least 2L vectors since clear), it traces back
// 2L steps from the best state: L convergence steps, then L decode steps. The decoded
// bits are then emitted oldest first, one per cycle.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   enable     0 = soft clear, same effect as rst
//   dec_valid  decision vector valid
//   dec_ready  buffer can accept a vector (low while a traceback is pending)
//   dec_in     decision bits, bit s = survivor decision for state s
//   best_state best-metric state, sampled with each accepted write
//   d_o        decoded bit (registered)
//   wr_en      d_o valid (registered)
module tbu_window #(
   parameter int M = 3,
   parameter int L = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               dec_valid,
   output logic               dec_ready,
   input  logic [(1<<M)-1:0]  dec_in,
   input  logic [M-1:0]       best_state,
   output logic               d_o,
   output logic               wr_en
);

   localparam int N  = 1 << M;
   localparam int D  = 3 * L;
   localparam int AW = $clog2(D);
   localparam int CW = $clog2(2 * L + 1);
   localparam int SW = (L > 1) ? $clog2(L) : 1;

   typedef enum logic [1:0] {IDLE, CONV, DECODE, EMIT} state_t;

   state_t          state, state_nxt;
   logic [N-1:0]    mem [D];
   logic [AW-1:0]   wptr, wptr_inc, wptr_dec;
   logic [AW-1:0]   raddr, raddr_dec;
   logic [CW-1:0]   fill;
   logic [M-1:0]    ts, start_state;
   logic [SW-1:0]   step;
   logic [L-1:0]    lifo;
   logic            pending;
   logic            clr, accept, seg_done, trigger, step_done, load_tb;
   logic [N-1:0]    rd_vec;
   logic            tb_bit;

   assign clr       = rst || !enable;
   assign dec_ready = !pending;

   always_comb begin
      accept    = dec_valid && dec_ready;
      wptr_inc  = (wptr == AW'(D - 1)) ? '0 : wptr + AW'(1);
      wptr_dec  = (wptr == '0) ? AW'(D - 1) : wptr - AW'(1);
      raddr_dec = (raddr == '0) ? AW'(D - 1) : raddr - AW'(1);
      seg_done  = (wptr_inc == AW'(0)) || (wptr_inc == AW'(L)) || (wptr_inc == AW'(2 * L));
      // fill counts writes before this one; this write makes it >= 2L
      trigger   = accept && seg_done && (fill >= CW'(2 * L - 1));
      step_done = (step == SW'(L - 1));
      rd_vec    = mem[raddr];
      tb_bit    = rd_vec[ts];
   end

   // Next-state logic. load_tb starts a new traceback, either from a fresh trigger
   // or from the pending request left by a completion that arrived while busy.
   always_comb begin
      state_nxt = state;
      load_tb   = 1'b0;
      case (state)
         IDLE: begin
            if (trigger || pending) begin
               state_nxt = CONV;
               load_tb   = 1'b1;
            end
         end
         CONV: begin
            if (step_done) state_nxt = DECODE;
         end
         DECODE: begin
            if (step_done) state_nxt = EMIT;
         end
         EMIT: begin
            if (step_done) begin
               if (trigger || pending) begin
                  state_nxt = CONV;
                  load_tb   = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) state <= IDLE;
      else     state <= state_nxt;
   end

   // Survivor memory has no reset: every entry is rewritten before it can be read.
   always_ff @(posedge clk) begin
      if (!clr && accept) mem[wptr] <= dec_in;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         wptr        <= '0;
         fill        <= '0;
         pending     <= 1'b0;
         start_state <= '0;
         ts          <= '0;
         raddr       <= '0;
         step        <= '0;
         lifo        <= '0;
         d_o         <= 1'b0;
         wr_en       <= 1'b0;
      end else begin
         if (accept) begin
            wptr        <= wptr_inc;
            start_state <= best_state;
            if (fill != CW'(2 * L)) fill <= fill + CW'(1);
         end

         // Writes stall while pending, so a trigger never coincides with pending.
         if (load_tb)      pending <= 1'b0;
         else if (trigger) pending <= 1'b1;

         if (state != IDLE) step <= step_done ? '0 : step + SW'(1);

         if (load_tb) begin
            if (trigger) begin
               ts    <= best_state;
               raddr <= wptr;
            end else begin
               // newest vector is the one that set pending; nothing written since
               ts    <= start_state;
               raddr <= wptr_dec;
            end
         end else if (state == CONV || state == DECODE) begin
            ts    <= M'({tb_bit, ts} >> 1);
            raddr <= raddr_dec;
         end

         if (state == DECODE) lifo[step] <= ts[0];

         // Decode pushed newest-first into lifo[0..L-1]; pop from the top for time order.
         if (state == EMIT) begin
            d_o   <= lifo[SW'(L - 1) - step];
            wr_en <= 1'b1;
         end else begin
            d_o   <= 1'b0;
            wr_en <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tbu_window.sv
// tb/tb_tbu_window.sv - directed self-checking bench for tbu_window (M=3, L=4)
module tb_tbu_window;

   localparam int M = 3;
   localparam int L = 4;
   localparam int D = 3 * L;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b1;
   logic       dec_valid = 1'b0;
   logic       dec_ready;
   logic [7:0] dec_in = '0;
   logic [2:0] best_state = '0;
   logic       d_o;
   logic       wr_en;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_t = 0;
   int nwr = 0;
   int tw [64];
   int bursts = 0;
   int run = 0;
   int b0;

   logic [7:0] mdl_mem [D];
   int         mdl_wptr = 0;
   logic       expq [$];

   tbu_window #(.M(M), .L(L)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .dec_valid  (dec_valid),
      .dec_ready  (dec_ready),
      .dec_in     (dec_in),
      .best_state (best_state),
      .d_o        (d_o),
      .wr_en      (wr_en)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference traceback: 2L steps back from the newest address, decode bits from the last L.
   task automatic model_trig(input logic [2:0] st, input int newest);
      logic [2:0]   t;
      logic [L-1:0] bits;
      logic         b;
      int           ra;
      t  = st;
      ra = newest;
      bits = '0;
      for (int k = 0; k < 2 * L; k++) begin
         b = mdl_mem[ra][t];
         if (k >= L) bits[k - L] = t[0];
         t  = {b, t[2:1]};
         ra = (ra == 0) ? D - 1 : ra - 1;
      end
      for (int k = L - 1; k >= 0; k--) expq.push_back(bits[k]);
   endtask

   task automatic model_write(input logic [7:0] d, input logic [2:0] bs);
      int old;
      old = mdl_wptr;
      mdl_mem[old] = d;
      mdl_wptr = (old + 1) % D;
      nwr++;
      tw[nwr] = last_t;
      if ((mdl_wptr % L) == 0 && nwr >= 2 * L) model_trig(bs, old);
   endtask

   task automatic clear_model();
      expq.delete();
      mdl_wptr = 0;
      nwr = 0;
   endtask

   task automatic send(input logic [7:0] d, input logic [2:0] bs);
      int waited;
      @(negedge clk);
      dec_valid  = 1'b1;
      dec_in     = d;
      best_state = bs;
      waited = 0;
      while (!dec_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!dec_ready) begin
         chk("rdy_timeout", dec_ready, 1);
         dec_valid = 1'b0;
         return;
      end
      last_t = cyc + 1;
      @(posedge clk);
      model_write(d, bs);
   endtask

   task automatic idle();
      @(negedge clk);
      dec_valid = 1'b0;
   endtask

   task automatic wait_cyc(input int t);
      int n;
      n = 0;
      while (cyc < t && n < 1000) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((expq.size() != 0 || wr_en) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain", expq.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset(input bit use_en);
      @(negedge clk);
      dec_valid = 1'b0;
      if (use_en) enable = 1'b0;
      else        rst = 1'b1;
      clear_model();
      @(negedge clk);
      rst = 1'b0;
      enable = 1'b1;
   endtask

   // Output monitor: every valid bit against the model queue, idle d_o, burst length.
   initial begin
      forever begin
         @(negedge clk);
         if (wr_en) begin
            run++;
            if (expq.size() == 0) chk("wr_extra", wr_en, 1'b0);
            else chk("d_o", d_o, expq.pop_front());
         end else begin
            chk("d_o_idle", d_o, 1'b0);
            if (run != 0) begin
               chk("burst_len", run, L);
               bursts++;
               run = 0;
            end
         end
      end
   end

   initial begin
      int t;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_wr_en", wr_en, 0);
      chk("rst_d_o", d_o, 0);
      chk("rst_ready", dec_ready, 1);

      // 1: all-ones decisions, best 7; exact latency window
      clear_model();
      for (int i = 0; i < 8; i++) send(8'hFF, 3'd7);
      t = last_t;
      idle();
      chk("rdy_trig", dec_ready, 1);
      wait_cyc(t + 2 * L);
      chk("wr_before", wr_en, 0);
      for (int i = 0; i < L; i++) begin
         @(negedge clk);
         chk("wr_window", wr_en, 1);
         chk("d_o_ones", d_o, 1);
      end
      @(negedge clk);
      chk("wr_after", wr_en, 0);
      drain();

      // 2: all-zero decisions, best 5
      do_reset(0);
      for (int i = 0; i < 8; i++) send(8'h00, 3'd5);
      idle();
      drain();

      // 3: all-ones, best 0; convergence removes start bias
      do_reset(0);
      for (int i = 0; i < 8; i++) send(8'hFF, 3'd0);
      idle();
      drain();

      // 4: continuous stream of 40 vectors, stall on second completion
      do_reset(0);
      b0 = bursts;
      for (int i = 1; i <= 40; i++) begin
         send(8'((i * 29 + 7) & 8'hFF), 3'(i % 8));
         if (i == 12) begin
            @(negedge clk);
            chk("rdy_stall", dec_ready, 0);
         end
      end
      idle();
      chk("stall_len", tw[13] - tw[12], 9);
      chk("trig8_ready", tw[9] - tw[8], 1);
      drain();
      chk("bursts40", bursts - b0, 9);

      // 5: reset and soft clear during DECODE
      for (int u = 0; u < 2; u++) begin
         do_reset(0);
         for (int i = 0; i < 8; i++) send(8'hA5, 3'd3);
         t = last_t;
         idle();
         wait_cyc(t + 5);
         if (u == 0) rst = 1'b1;
         else        enable = 1'b0;
         clear_model();
         @(negedge clk);
         rst = 1'b0;
         enable = 1'b1;
         chk("abort_wr_en", wr_en, 0);
         chk("abort_d_o", d_o, 0);
         chk("abort_ready", dec_ready, 1);
         b0 = bursts;
         for (int i = 0; i < 7; i++) send(8'hFF, 3'd6);
         idle();
         repeat (30) @(negedge clk);
         chk("no_early_trig", bursts - b0, 0);
         send(8'hFF, 3'd6);
         idle();
         drain();
         chk("fresh_trig", bursts - b0, 1);
      end

      // 6: distinct vectors, third window straddles address 0
      do_reset(0);
      b0 = bursts;
      for (int i = 0; i < 16; i++) send(8'((i * 53 + 29) & 8'hFF), 3'(i % 8));
      idle();
      drain();
      chk("bursts_wrap", bursts - b0, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
